// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the two-port UART transmit arbiter.
package uart_arb_pkg;

  localparam int BYTE_W            = 8;
  localparam int FIFO_DEPTH_DEF    = 4;
  localparam int READY_TIMEOUT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH
  } arb_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO is dropped even if a pop
// happens in the same cycle.
module uart_byte_fifo
  import uart_arb_pkg::*;
#(
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [PTR_W:0]    o_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [BYTE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push_en;
  logic              w_pop_en;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_en = i_push && !o_full;
  assign w_pop_en  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from two byte FIFOs
// (port 0 = CPU, port 1 = debug/trace) over a send-request/ready handshake.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int READY_TIMEOUT = READY_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [BYTE_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_send_req,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              grant_id,
  output logic              proto_err
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int              TO_W    = $clog2(READY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(READY_TIMEOUT - 1);

  arb_state_t        r_state;
  logic              r_tx_send_req;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_grant_id;
  logic              r_last_grant;
  logic              r_proto_err;
  logic [TO_W-1:0]   r_to_cnt;

  logic [BYTE_W-1:0] w_head0, w_head1;
  logic              w_full0, w_full1;
  logic              w_empty0, w_empty1;
  logic [CNT_W-1:0]  w_count0, w_count1;
  logic              w_start;
  logic              w_sel;
  logic              w_pop0, w_pop1;

  uart_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (req0_valid),
    .i_data  (req0_data),
    .i_pop   (w_pop0),
    .o_data  (w_head0),
    .o_full  (w_full0),
    .o_empty (w_empty0),
    .o_count (w_count0)
  );

  uart_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (req1_valid),
    .i_data  (req1_data),
    .i_pop   (w_pop1),
    .o_data  (w_head1),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_count (w_count1)
  );

  // With both FIFOs pending the port that did not win last time goes next.
  assign w_sel   = (!w_empty0 && !w_empty1) ? ~r_last_grant : w_empty0;
  assign w_start = (r_state == IDLE) && tx_ready && (!w_empty0 || !w_empty1);
  assign w_pop0  = w_start && !w_sel;
  assign w_pop1  = w_start && w_sel;

  assign req0_ready  = !w_full0;
  assign req1_ready  = !w_full1;
  assign busy        = (r_state != IDLE) || (w_count0 != '0) || (w_count1 != '0);
  assign tx_send_req = r_tx_send_req;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign proto_err   = r_proto_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_tx_send_req <= 1'b0;
      r_tx_data     <= '0;
      r_grant_id    <= 1'b0;
      r_last_grant  <= 1'b1;
      r_proto_err   <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_tx_send_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_tx_data     <= w_sel ? w_head1 : w_head0;
            r_grant_id    <= w_sel;
            r_last_grant  <= w_sel;
            r_tx_send_req <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= WAIT_LOW;
        end
        // A transmitter that never drops ready loses the byte and flags the error.
        WAIT_LOW: begin
          if (!tx_ready) begin
            r_state <= WAIT_HIGH;
          end else if (r_to_cnt == TO_LAST) begin
            r_proto_err <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (tx_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transmitter model and byte scoreboard.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       tx_send_req;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       grant_id;
  logic       proto_err;

  uart_tx_arbiter #(.FIFO_DEPTH(4), .READY_TIMEOUT(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .tx_send_req (tx_send_req),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .grant_id    (grant_id),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       er0;
    logic       er1;
  } vec_t;

  localparam int TX_BUSY = 4;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   send_cnt = 0;
  int   last_send_cyc = 0;
  int   busy_cnt = 0;
  logic prev_send = 1'b0;
  logic model_ready = 1'b1;
  logic stuck = 1'b0;
  logic force_low = 1'b0;

  assign tx_ready = model_ready && !force_low;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: drops ready right after seeing a request, busy for TX_BUSY cycles.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && tx_send_req) begin
      send_cnt      <= send_cnt + 1;
      last_send_cyc <= cyc;
      check("no_back_to_back", {31'd0, prev_send}, 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_send: got %0h expected no request", tx_data);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
        check("grant_id", {31'd0, grant_id}, {31'd0, e.id});
      end
      if (!stuck) begin
        model_ready <= 1'b0;
        busy_cnt    <= TX_BUSY;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt    <= busy_cnt - 1;
      model_ready <= (busy_cnt == 1);
    end
    prev_send <= tx_send_req;
  end

  task automatic wait_send(input int target, input int budget, input string name);
    int k = 0;
    while (send_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, {31'd0, send_cnt >= target}, 1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy || !tx_ready) && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, {29'd0, exp_q.size() == 0, busy, tx_ready}, 3'b101);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_send_req"}, {31'd0, tx_send_req}, 0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 0);
    check({tag, "_grant_id"}, {31'd0, grant_id}, 0);
    check({tag, "_proto_err"}, {31'd0, proto_err}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_ready0"}, {31'd0, req0_ready}, 1);
    check({tag, "_ready1"}, {31'd0, req1_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[5];
    int   t0;
    int   s0;
    logic seen;

    vt[0] = '{1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b1};
    vt[1] = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1};
    vt[2] = '{1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1'b1};
    vt[3] = '{1'b1, 8'hA3, 1'b1, 8'hB3, 1'b1, 1'b1};
    vt[4] = '{1'b1, 8'hA4, 1'b1, 8'hB4, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Both ports filled while the transmitter is held busy; fifth bytes dropped.
    force_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req0_valid = vt[i].v0; req0_data = vt[i].d0;
      req1_valid = vt[i].v1; req1_data = vt[i].d1;
      check($sformatf("vec%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vt[i].er0});
      check($sformatf("vec%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vt[i].er1});
      if (vt[i].v0 && vt[i].er0) exp_q.push_back(exp_t'{1'b0, vt[i].d0});
      if (vt[i].v1 && vt[i].er1) exp_q.push_back(exp_t'{1'b1, vt[i].d1});
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    force_low = 1'b0;
    drain("rr_order_drain");

    // Single byte latency and handshake.
    @(negedge clk);
    t0 = cyc; s0 = send_cnt;
    req0_valid = 1'b1; req0_data = 8'h55;
    exp_q.push_back(exp_t'{1'b0, 8'h55});
    @(negedge clk);
    req0_valid = 1'b0;
    check("single_busy_after_push", {31'd0, busy}, 1);
    wait_send(s0 + 1, 10, "single_send_seen");
    check("single_latency", last_send_cyc - t0, 2);
    repeat (8) @(negedge clk);
    #1;
    check("single_one_pulse", send_cnt, s0 + 1);
    check("single_busy_low", {31'd0, busy}, 0);

    // Port 1 overfilled while the transmitter is busy; held 5th byte enters after a pop.
    force_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req1_valid = 1'b1; req1_data = 8'hC0 + 8'(i);
      check($sformatf("p1_ready_%0d", i), {31'd0, req1_ready}, 1);
      exp_q.push_back(exp_t'{1'b1, 8'hC0 + 8'(i)});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req1_data = 8'hC4;
      check("p1_full", {31'd0, req1_ready}, 0);
    end
    force_low = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = req1_ready;
    end
    check("p1_ready_after_pop", {31'd0, seen}, 1);
    exp_q.push_back(exp_t'{1'b1, 8'hC4});
    @(negedge clk);
    req1_valid = 1'b0;
    drain("p1_overfill_drain");

    // Transmitter never drops ready: timeout sets sticky proto_err.
    @(negedge clk);
    stuck = 1'b1;
    s0 = send_cnt;
    req0_valid = 1'b1; req0_data = 8'hE0;
    exp_q.push_back(exp_t'{1'b0, 8'hE0});
    @(negedge clk);
    req0_valid = 1'b0;
    wait_send(s0 + 1, 10, "timeout_send_seen");
    check("timeout_err_early", {31'd0, proto_err}, 0);
    repeat (3) @(negedge clk);
    #1;
    check("timeout_err_before_3rd", {31'd0, proto_err}, 0);
    @(negedge clk); #1;
    check("timeout_err_set", {31'd0, proto_err}, 1);
    stuck = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hE1;
    exp_q.push_back(exp_t'{1'b0, 8'hE1});
    @(negedge clk);
    req0_valid = 1'b0;
    wait_send(s0 + 2, 10, "timeout_next_send");
    drain("timeout_drain");
    check("timeout_err_sticky", {31'd0, proto_err}, 1);

    // Simultaneous push and pop on port 0 keeps the count unchanged.
    force_low = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_data = 8'hD0 + 8'(i);
      exp_q.push_back(exp_t'{1'b0, 8'hD0 + 8'(i)});
    end
    @(negedge clk);
    force_low = 1'b0;
    req0_data = 8'hD2;
    exp_q.push_back(exp_t'{1'b0, 8'hD2});
    @(negedge clk);
    req0_data = 8'hD3;
    exp_q.push_back(exp_t'{1'b0, 8'hD3});
    @(negedge clk);
    check("pushpop_ready_cnt3", {31'd0, req0_ready}, 1);
    req0_data = 8'hD4;
    exp_q.push_back(exp_t'{1'b0, 8'hD4});
    @(negedge clk);
    req0_valid = 1'b0;
    check("pushpop_full_cnt4", {31'd0, req0_ready}, 0);
    drain("pushpop_drain");

    // Reset during WAIT_HIGH with two bytes queued.
    s0 = send_cnt;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hF0;
    exp_q.push_back(exp_t'{1'b0, 8'hF0});
    @(negedge clk);
    req0_data = 8'hF1;
    @(negedge clk);
    req0_data = 8'hF2;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("midreset_sent_first", send_cnt, s0 + 1);
    check("midreset_busy_before", {31'd0, busy}, 1);
    check("midreset_tx_ready_low", {31'd0, tx_ready}, 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("midreset_no_send", send_cnt, s0 + 1);
    check("midreset_idle", {31'd0, busy}, 0);

    // After reset port 0 wins a simultaneous request.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h3C;
    req1_valid = 1'b1; req1_data = 8'h4D;
    exp_q.push_back(exp_t'{1'b0, 8'h3C});
    exp_q.push_back(exp_t'{1'b1, 8'h4D});
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("post_reset_rr_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
